alu: RTL and testbench
======================

Name: alu

Overview:
- Parameterised n-bit arithmetic/logic unit with registered result and NZCV status flags.
- Sits in the datapath after operand selection. One operation per clock on operands a/b, chosen by a 3-bit opcode.
- Result and flags appear one cycle after the operands are sampled.

Parameters:
- n, 4, datapath width in bits (legal range ≥2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  sample enable; operands/op captured when high
- a  input  n  operand A
- b  input  n  operand B (ignored for shifts and op 7)
- op  input  3  operation select
- res  output  n  registered result
- N  output  1  negative flag
- Z  output  1  zero flag
- C  output  1  carry/borrow/shift-out flag
- V  output  1  signed overflow flag
- out_valid  output  1  high for one cycle after each enabled sample

Behaviour:
- Reset: rst_n low asynchronously forces res=0, N=0, Z=0, C=0, V=0, out_valid=0, regardless of clk. Release is synchronous to the next rising edge.
- Latency: combinational compute, single output register stage.
  - At a rising edge with en=1, res/flags load the result of (a, b, op) present before the edge, and out_valid=1.
  - With en=0, res/flags hold their previous values and out_valid=0.
- Opcodes (all arithmetic modulo 2^n):
  - 0 ADD: res=a+b. C=carry out of bit n-1. V=1 when a and b have the same sign and res has the opposite sign.
  - 1 SUB: res=a−b, computed as a+~b+1. C=carry out of that sum (C=1 means no borrow, i.e. a≥b unsigned). V=1 when a and b signs differ and res sign differs from a.
  - 2 SHR: logical shift right by 1, MSB filled with 0. C=a[0]. V=0.
  - 3 SHL: logical shift left by 1, LSB filled with 0. C=a[n-1]. V=0.
  - 4 AND: res=a&b. C=0, V=0.
  - 5 OR: res=a|b. C=0, V=0.
  - 6 XOR: res=a^b. C=0, V=0.
  - 7 NOT: res=~a. C=0, V=0.
- For all ops: N=res[n-1]; Z=1 when res==0.
- Flags are always computed from the same op as res. There is no flag accumulation across cycles.
- Boundaries:
  - Wrap-around on ADD (15+15→14 at n=4) sets C.
  - SUB of equal operands gives res=0, Z=1, C=1.
  - SUB with a<b gives C=0.
  - Shift of a zero operand gives Z=1, C=0.
- Reset asserted mid-stream discards any pending result. The first enabled edge after release produces a fresh result.
- Inputs changing while en=0 have no effect on outputs.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: ADD and SUB saturate unsigned.
  - ADD with carry out gives res = all ones.
  - SUB with borrow (C=0) gives res=0.
  - C and V still report the unsaturated carry/overflow; N and Z are computed from the saturated res.
- Not defined: ADD/SUB wrap modulo 2^n as specified above. All other ops are unaffected either way.

Test Plan (n=4, ALU_SAT_EN undefined unless stated):
- Reset: hold rst_n=0, toggle clk and inputs → res=0, NZCV=0000, out_valid=0. Assert rst_n low between edges → outputs clear immediately.
- ADD: a=15,b=15 → res=14, N1 Z0 C1 V0. a=5,b=3 → res=8, N1 C0 V1. a=0,b=0 → res=0, Z1.
- SUB: a=8,b=15 → res=9, N1 C0 V0. a=8,b=8 → res=0, Z1 C1. a=10,b=4 → res=6, C1 V1.
- Shifts: SHR a=5 → res=2, C1. SHR a=10 → res=5, C0. SHL a=12 → res=8, C1, N1. SHL a=3 → res=6, C0.
- Logic: AND 8,12 → 8, N1. AND 4,2 → 0, Z1. OR 10,3 → 11. XOR 14,5 → 11. XOR 8,1 → 9. NOT 15 → 0, Z1. en=0 for 3 cycles → outputs hold, out_valid=0.
- ALU_SAT_EN defined: ADD 15+15 → res=15, C1. SUB 0−15 → res=0, Z1, C0.

Source files
------------

// File: rtl/alu.sv
// n-bit ALU with a single registered output stage for result, NZCV flags and out_valid.
// Optional build macro ALU_SAT_EN: ADD/SUB saturate unsigned instead of wrapping.
module alu #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [2:0]   op,
    output logic [n-1:0] res,
    output logic         N,
    output logic         Z,
    output logic         C,
    output logic         V,
    output logic         out_valid
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SHR = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    logic [n-1:0] b_op_s;
    logic         cin_s;
    logic [n:0]   sum_s;
    logic [n-1:0] res_s;
    logic         c_s;
    logic         v_s;

    logic [n-1:0] res_r;
    logic         n_r;
    logic         z_r;
    logic         c_r;
    logic         v_r;
    logic         out_valid_r;

    // Shared adder: SUB is a + ~b + 1 so its carry out means "no borrow".
    always_comb begin
        b_op_s = b;
        cin_s  = 1'b0;
        if (op == OP_SUB) begin
            b_op_s = ~b;
            cin_s  = 1'b1;
        end else begin
            b_op_s = b;
            cin_s  = 1'b0;
        end
        sum_s = {1'b0, a} + {1'b0, b_op_s} + {{n{1'b0}}, cin_s};
    end

    // Result and carry/overflow selection per opcode.
    always_comb begin
        res_s = {n{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (op)
            OP_ADD: begin
                c_s = sum_s[n];
                v_s = (a[n-1] == b[n-1]) && (sum_s[n-1] != a[n-1]);
`ifdef ALU_SAT_EN
                if (sum_s[n]) begin
                    res_s = {n{1'b1}};
                end else begin
                    res_s = sum_s[n-1:0];
                end
`else
                res_s = sum_s[n-1:0];
`endif
            end
            OP_SUB: begin
                c_s = sum_s[n];
                v_s = (a[n-1] != b[n-1]) && (sum_s[n-1] != a[n-1]);
`ifdef ALU_SAT_EN
                if (!sum_s[n]) begin
                    res_s = {n{1'b0}};
                end else begin
                    res_s = sum_s[n-1:0];
                end
`else
                res_s = sum_s[n-1:0];
`endif
            end
            OP_SHR: begin
                res_s = {1'b0, a[n-1:1]};
                c_s   = a[0];
            end
            OP_SHL: begin
                res_s = {a[n-2:0], 1'b0};
                c_s   = a[n-1];
            end
            OP_AND:  res_s = a & b;
            OP_OR:   res_s = a | b;
            OP_XOR:  res_s = a ^ b;
            OP_NOT:  res_s = ~a;
            default: res_s = {n{1'b0}};
        endcase
    end

    // Output register: load on enable, otherwise hold result/flags and drop out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r       <= {n{1'b0}};
            n_r         <= 1'b0;
            z_r         <= 1'b0;
            c_r         <= 1'b0;
            v_r         <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (en) begin
            res_r       <= res_s;
            n_r         <= res_s[n-1];
            z_r         <= (res_s == {n{1'b0}});
            c_r         <= c_s;
            v_r         <= v_s;
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign res       = res_r;
    assign N         = n_r;
    assign Z         = z_r;
    assign C         = c_r;
    assign V         = v_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu at n=4; expectations are hand-computed constants.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic       N;
    logic       Z;
    logic       C;
    logic       V;
    logic       out_valid;

    int vectors;
    int miscompares;

    alu #(.n(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .op(op),
        .res(res), .N(N), .Z(Z), .C(C), .V(V), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] er, input logic en_, input logic ez,
                         input logic ec, input logic ev, input logic eov);
        vectors++;
        assert ({res, N, Z, C, V, out_valid} === {er, en_, ez, ec, ev, eov})
        else begin
            miscompares++;
            $error("FAIL %s: got res=%0d NZCV=%b%b%b%b valid=%b, want res=%0d NZCV=%b%b%b%b valid=%b",
                   tag, res, N, Z, C, V, out_valid, er, en_, ez, ec, ev, eov);
        end
    endtask

    // Apply one enabled operation, then sample 1 time unit after the edge.
    task automatic step(input logic [2:0] o, input logic [3:0] aa, input logic [3:0] bb);
        op = o;
        a  = aa;
        b  = bb;
        en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        a     = 4'd15;
        b     = 4'd15;
        op    = 3'd0;

        // Reset held across edges with inputs moving
        repeat (3) begin
            @(posedge clk);
            a = a - 4'd3;
            b = b + 4'd5;
            #1;
        end
        check("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        step(3'd0, 4'd15, 4'd15); check("add_15_15", 4'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(3'd0, 4'd5,  4'd3);  check("add_5_3",   4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(3'd0, 4'd0,  4'd0);  check("add_0_0",   4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(3'd0, 4'd7,  4'd1);  check("add_7_1",   4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(3'd1, 4'd8,  4'd15); check("sub_8_15",  4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(3'd1, 4'd8,  4'd8);  check("sub_8_8",   4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(3'd1, 4'd10, 4'd4);  check("sub_10_4",  4'd6,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(3'd1, 4'd1,  4'd8);  check("sub_1_8",   4'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(3'd2, 4'd5,  4'd9);  check("shr_5",     4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(3'd2, 4'd10, 4'd3);  check("shr_10",    4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(3'd3, 4'd12, 4'd0);  check("shl_12",    4'd8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(3'd3, 4'd3,  4'd15); check("shl_3",     4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(3'd2, 4'd0,  4'd15); check("shr_0",     4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(3'd3, 4'd0,  4'd15); check("shl_0",     4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(3'd4, 4'd8,  4'd12); check("and_8_12",  4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(3'd4, 4'd4,  4'd2);  check("and_4_2",   4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(3'd5, 4'd10, 4'd3);  check("or_10_3",   4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(3'd6, 4'd14, 4'd5);  check("xor_14_5",  4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(3'd6, 4'd8,  4'd1);  check("xor_8_1",   4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(3'd7, 4'd15, 4'd6);  check("not_15",    4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(3'd7, 4'd5,  4'd0);  check("not_5",     4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Hold with en low while inputs change
        step(3'd0, 4'd15, 4'd15);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op = 3'(i + 4);
            a  = 4'(i * 5);
            b  = 4'(i + 1);
            @(posedge clk);
            #1;
            check("en_low_hold", 4'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end

`ifdef ALU_SAT_EN
        step(3'd0, 4'd15, 4'd15); check("sat_add_15_15", 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(3'd1, 4'd0,  4'd15); check("sat_sub_0_15",  4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(3'd0, 4'd9,  4'd3);  check("sat_add_nosat", 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        step(3'd1, 4'd0,  4'd15); check("sub_0_15",      4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Async reset between edges clears immediately
        step(3'd5, 4'd12, 4'd3);
        check("pre_async", 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Pending operation under reset is discarded
        op = 3'd7; a = 4'd0; b = 4'd0; en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_discard", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(3'd0, 4'd2, 4'd3); check("after_rst", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
